rf_wb_arbiter: RTL

//  Owns the single register-file write port. Shares it between the in-order pipeline WB stage
//  and a long-latency unit (mult/div) that returns results out of band. Keeps a 32-entry

---
 rtl/rf_wb_arbiter.sv | 95 +++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the RF write port between WB and a long-latency unit, with busy scoreboard and starvation drain (optional RF_ARB_STATS_EN adds stat_force_cycles)
module rf_wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_reg_write,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              lu_issue,
  input  logic [ADDR_W-1:0] lu_issue_rd,
  input  logic              lu_valid,
  input  logic [ADDR_W-1:0] lu_waddr,
  input  logic [DATA_W-1:0] lu_wdata,
  output logic              lu_ready,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic [ADDR_W-1:0] id_rd,
  output logic              stall_id,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
`ifdef RF_ARB_STATS_EN
  output logic [15:0]       stat_force_cycles,
`endif
  output logic              lu_pending
);
  localparam int N = 2 ** ADDR_W;
  typedef enum logic [1:0] {IDLE, HOLD, FORCE} state_t;
  state_t            state_q, state_d;
  logic              hold_valid_q, hold_valid_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic [N-1:0]      busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              drain, accept;
  assign lu_ready   = ~hold_valid_q;
  assign accept     = lu_valid & lu_ready;
  assign drain      = hold_valid_q & ~wb_reg_write;
  assign rf_we      = wb_reg_write | hold_valid_q;
  assign rf_waddr   = wb_reg_write ? wb_waddr : hold_addr_q;
  assign rf_wdata   = wb_reg_write ? wb_wdata : hold_data_q;
  assign lu_pending = hold_valid_q | (|busy_q);
  // busy_q[0] is held at 0, so $0 sources never stall
  assign stall_id   = busy_q[id_rs] | busy_q[id_rt] | busy_q[id_rd] | (state_q == FORCE);
  always_comb begin
    hold_valid_d = drain ? 1'b0 : (accept ? 1'b1 : hold_valid_q);
    hold_addr_d  = accept ? lu_waddr : hold_addr_q;
    hold_data_d  = accept ? lu_wdata : hold_data_q;
    busy_d = busy_q;
    if (drain) busy_d[hold_addr_q] = 1'b0;
    if (lu_issue) busy_d[lu_issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (drain) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (state_q == HOLD) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_d == CNT_W'(STARVE_LIMIT)) state_d = FORCE;
    end else if (accept) begin
      state_d = HOLD;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      hold_valid_q <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      busy_q       <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      hold_valid_q <= hold_valid_d;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
      busy_q       <= busy_d;
      cnt_q        <= cnt_d;
    end
  end
`ifdef RF_ARB_STATS_EN
  logic [15:0] stat_q, stat_d;
  assign stat_force_cycles = stat_q;
  always_comb stat_d = (state_q == FORCE && stat_q != 16'hFFFF) ? stat_q + 16'd1 : stat_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stat_q <= '0;
    else stat_q <= stat_d;
  end
`endif
endmodule
